// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the multiply-accumulate stages: default datapath widths,
// window counter width and the accumulator state encoding.
package product_accumulator_pkg;

    localparam int PA_PROD_W = 4;   // matches the multiplier product width
    localparam int PA_ACC_W  = 8;
    localparam int PA_CNT_W  = 8;   // holds any legal window size (1..255)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } pa_state_e;

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Purpose: unsigned a+b clamped to all-ones, with a flag when the clamp engaged.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sat_add #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] a_dat,
    input  logic [ACC_W-1:0] b_dat,
    output logic [ACC_W-1:0] sum_dat,
    output logic             ovf
);

    logic [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, a_dat} + {1'b0, b_dat};
        ovf      = wide_sum[ACC_W];
        sum_dat  = wide_sum[ACC_W] ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// Purpose: sums WINDOW multiplier products into a saturating total with overflow flag.
// Latency: result valid the cycle after the WINDOW-th accepted product.
// Backpressure: in_ready drops while a result waits for out_ready; no result-to-input bypass.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PA_PROD_W,
    parameter int ACC_W  = PA_ACC_W,
    parameter int WINDOW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    pa_state_e            state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [PA_CNT_W-1:0]  cnt_q, cnt_d;
    logic                 ovf_acc_q, ovf_acc_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_W-1:0]     out_sum_q, out_sum_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [PROD_W-1:0]    prod_masked;
    logic [ACC_W-1:0]     prod_ext;
    logic [ACC_W-1:0]     add_sum;
    logic                 add_ovf;
    logic                 accept;
    logic                 last_sample;

    // Masking with in_valid keeps an undriven product from reaching the adder.
    assign prod_masked = in_valid ? in_prod : '0;
    assign prod_ext    = ACC_W'(prod_masked);

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a_dat   (acc_q),
        .b_dat   (prod_ext),
        .sum_dat (add_sum),
        .ovf     (add_ovf)
    );

    assign in_ready    = (state_q != ST_HOLD);
    assign accept      = in_valid & in_ready;
    assign last_sample = (cnt_q == PA_CNT_W'(WINDOW - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (clear) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        if (last_sample) begin
                            out_sum_d   = add_sum;
                            out_ovf_d   = ovf_acc_q | add_ovf;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            ovf_acc_d   = 1'b0;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d     = add_sum;
                            cnt_d     = cnt_q + 1'b1;
                            ovf_acc_d = ovf_acc_q | add_ovf;
                            state_d   = ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_acc_d   = 1'b0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: an 8-bit and a 5-bit accumulator instance, expected
// window totals queued at stimulus time and compared when each result handshakes.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit accumulator instance
    logic       clear8, in_valid8, in_ready8, out_valid8, out_ready8, out_ovf8;
    logic [3:0] in_prod8;
    logic [7:0] out_sum8;
    // 5-bit accumulator instance
    logic       clear5, in_valid5, in_ready5, out_valid5, out_ready5, out_ovf5;
    logic [3:0] in_prod5;
    logic [4:0] out_sum5;

    logic rdy_cmd, rand_mode, rnd_bit;
    assign out_ready8 = rand_mode ? rnd_bit : rdy_cmd;
    assign out_ready5 = 1'b1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    product_accumulator #(.PROD_W(4), .ACC_W(8), .WINDOW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_prod(in_prod8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_sum(out_sum8), .out_ovf(out_ovf8)
    );

    product_accumulator #(.PROD_W(4), .ACC_W(5), .WINDOW(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear5),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_prod(in_prod5),
        .out_valid(out_valid5), .out_ready(out_ready5),
        .out_sum(out_sum5), .out_ovf(out_ovf5)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] q8[$];   // {ovf, sum}
    logic [8:0] q5[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: unsaturated total of the window, clamped; the flag is set when
    // any running sum passed the maximum, which for unsigned addends means the total did.
    function automatic logic [8:0] model(input int p0, p1, p2, p3, input int accw);
        int total, maxv;
        total = p0 + p1 + p2 + p3;
        maxv  = (1 << accw) - 1;
        if (total > maxv) return {1'b1, 8'(maxv)};
        return {1'b0, 8'(total)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (q8.size() == 0) chk("unexpected8", 1, 0);
            else begin
                logic [8:0] e;
                e = q8.pop_front();
                chk("sum8", 32'(out_sum8), 32'(e[7:0]));
                chk("ovf8", 32'(out_ovf8), 32'(e[8]));
            end
        end
        if (rst_n && out_valid5 && out_ready5) begin
            if (q5.size() == 0) chk("unexpected5", 1, 0);
            else begin
                logic [8:0] e;
                e = q5.pop_front();
                chk("sum5", 32'(out_sum5), 32'(e[7:0]));
                chk("ovf5", 32'(out_ovf5), 32'(e[8]));
            end
        end
    end

    task automatic send8(input logic [3:0] p, input int gap);
        bit ok;
        ok = 1'b0;
        in_valid8 = 1'b1;
        in_prod8  = p;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = in_ready8;
            @(posedge clk); #1;
        end
        if (!ok) chk("send8_timeout", 0, 1);
        in_valid8 = 1'b0;
        in_prod8  = 'x;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send5(input logic [3:0] p);
        bit ok;
        ok = 1'b0;
        in_valid5 = 1'b1;
        in_prod5  = p;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = in_ready5;
            @(posedge clk); #1;
        end
        if (!ok) chk("send5_timeout", 0, 1);
        in_valid5 = 1'b0;
        in_prod5  = 'x;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && (q8.size() != 0 || q5.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_drain8"}, 32'(q8.size()), 0);
        chk({tag, "_drain5"}, 32'(q5.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p[4];
        rst_n = 1'b0;
        clear8 = 1'b0; in_valid8 = 1'b0; in_prod8 = '0;
        clear5 = 1'b0; in_valid5 = 1'b0; in_prod5 = '0;
        rdy_cmd = 1'b1; rand_mode = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_in_ready", 32'(in_ready8), 1);
        chk("rst_out_valid", 32'(out_valid8), 0);
        chk("rst_out_sum", 32'(out_sum8), 0);
        chk("rst_out_ovf", 32'(out_ovf8), 0);

        // Back-to-back window, result one cycle after the last accept
        q8.push_back(model(1, 0, 0, 3, 8));
        send8(1, 0); send8(0, 0); send8(0, 0); send8(3, 0);
        chk("t1_vld_next", 32'(out_valid8), 1);
        chk("t1_rdy_low", 32'(in_ready8), 0);
        @(posedge clk); #1;
        chk("t1_vld_drop", 32'(out_valid8), 0);
        chk("t1_rdy_back", 32'(in_ready8), 1);
        drain("t1");

        // Bubbles between every product
        q8.push_back(model(4, 6, 9, 9, 8));
        send8(4, 2); send8(6, 3); send8(9, 1); send8(9, 2);
        drain("t2");

        // Saturation on a 5-bit accumulator, then a clean window
        q5.push_back(model(9, 9, 9, 9, 5));
        send5(9); send5(9); send5(9); send5(9);
        q5.push_back(model(1, 1, 1, 1, 5));
        send5(1); send5(1); send5(1); send5(1);
        drain("t3");

        // Result stalled by downstream while upstream keeps offering
        rdy_cmd = 1'b0;
        q8.push_back(model(2, 3, 1, 1, 8));
        send8(2, 0); send8(3, 0); send8(1, 0); send8(1, 0);
        in_valid8 = 1'b1;
        in_prod8  = 4'd5;
        for (int i = 0; i < 5; i++) begin
            chk("t4_rdy_low", 32'(in_ready8), 0);
            chk("t4_sum_hold", 32'(out_sum8), 7);
            chk("t4_vld_hold", 32'(out_valid8), 1);
            @(posedge clk); #1;
        end
        rdy_cmd = 1'b1;
        @(posedge clk); #1;
        chk("t4_vld_drop", 32'(out_valid8), 0);
        chk("t4_rdy_back", 32'(in_ready8), 1);
        q8.push_back(model(5, 5, 5, 5, 8));
        send8(5, 0); send8(5, 0); send8(5, 0); send8(5, 0);
        drain("t4");

        // Asynchronous reset mid-window
        send8(3, 0); send8(4, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", 32'(out_valid8), 0);
        chk("t5_rst_sum", 32'(out_sum8), 0);
        chk("t5_rst_ovf", 32'(out_ovf8), 0);
        chk("t5_rst_rdy", 32'(in_ready8), 1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        q8.push_back(model(1, 1, 1, 1, 8));
        send8(1, 0); send8(1, 0); send8(1, 0); send8(1, 0);
        drain("t5");

        // clear coinciding with a product drops it and the partial window
        send8(1, 0); send8(1, 1); send8(1, 0);
        in_valid8 = 1'b1;
        in_prod8  = 4'd9;
        clear8    = 1'b1;
        @(posedge clk); #1;
        clear8    = 1'b0;
        in_valid8 = 1'b0;
        chk("t6_rdy", 32'(in_ready8), 1);
        chk("t6_vld", 32'(out_valid8), 0);
        chk("t6_sum_keep", 32'(out_sum8), 4);
        q8.push_back(model(2, 2, 2, 2, 8));
        send8(2, 0); send8(2, 0); send8(2, 0); send8(2, 0);
        drain("t6");

        // Random products, gaps and downstream readiness
        rand_mode = 1'b1;
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 4; k++) p[k] = $urandom_range(0, 15);
            q8.push_back(model(p[0], p[1], p[2], p[3], 8));
            for (int k = 0; k < 4; k++) send8(4'(p[k]), $urandom_range(0, 2));
        end
        drain("t7");
        rand_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
